// File: rtl/lcd_pkg.sv
// lcd_pkg: mode encodings, RGB565 field widths and the colour-bar table
// Shared by lcd_timing_engine and lcd_pattern_gen; no ports.
package lcd_pkg;
  typedef enum logic [2:0] {
    M_BLACK  = 3'd0,
    M_BARS   = 3'd1,
    M_GRAD   = 3'd2,
    M_CHECK  = 3'd3,
    M_SOLID  = 3'd4,
    M_STREAM = 3'd5
  } mode_e;
  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;
  // index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][15:0] BAR_RGB = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                          16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};
endpackage

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: stage1 registered RGB565 test-pattern colour for one pixel
// Ports: PixelClk/nRST clock and async active-low reset; active, x, y pixel
// position; mode and solid_rgb frame-latched selection; rgb registered colour
// (0 outside the active area and in stream mode, which the top fills in).
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE   = 1024,
  parameter int CHECK_LOG2 = 5
) (
  input  logic        PixelClk,
  input  logic        nRST,
  input  logic        active,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [2:0]  mode,
  input  logic [15:0] solid_rgb,
  output logic [15:0] rgb
);
  localparam int          BAR_W   = H_ACTIVE / 8;
  localparam logic [15:0] BAR_DIV = 16'(BAR_W > 0 ? BAR_W : 1);
  localparam logic [15:0] BAR_END = 16'(BAR_W * 8);
  logic [2:0]  bar_idx;
  logic [15:0] bar_rgb, grad_rgb, chk_rgb, rgb_d;
  logic        unused_ok;
  assign unused_ok = ^{x, y};
  always_comb begin
    bar_idx  = 3'(x / BAR_DIV);
    bar_rgb  = x < BAR_END ? BAR_RGB[bar_idx] : 16'h0000;
    grad_rgb = {x[9:5], x[9:4], y[8:4]};
    chk_rgb  = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? 16'hFFFF : 16'h0000;
    rgb_d    = !active          ? 16'h0000 :
               mode == M_BARS   ? bar_rgb  :
               mode == M_GRAD   ? grad_rgb :
               mode == M_CHECK  ? chk_rgb  :
               mode == M_SOLID  ? solid_rgb : 16'h0000;
  end
  always_ff @(posedge PixelClk or negedge nRST)
    if (!nRST) rgb <= '0;
    else rgb <= rgb_d;
endmodule

// File: rtl/lcd_timing_engine.sv
// lcd_timing_engine: parametrised RGB565 LCD timing, pattern and stream engine
// Ports: PixelClk/nRST clock and async active-low reset; mode/solid_rgb
// pattern select; pix_rd/pix_data/pix_empty stream FIFO port; line_fetch/
// fetch_line prefetch request; frame_start pulse; underflow/underflow_clr
// sticky flag; LCD_DE/HSYNC/VSYNC/R/G/B panel pins (2-cycle latency).
module lcd_timing_engine
  import lcd_pkg::*;
#(
  parameter int          H_ACTIVE      = 1024,
  parameter int          H_PULSE       = 1,
  parameter int          H_BP          = 182,
  parameter int          H_FP          = 210,
  parameter int          V_ACTIVE      = 600,
  parameter int          V_PULSE       = 5,
  parameter int          V_BP          = 0,
  parameter int          V_FP          = 45,
  parameter bit          HS_POL        = 1'b0,
  parameter bit          VS_POL        = 1'b0,
  parameter int          CHECK_LOG2    = 5,
  parameter logic [15:0] UNDERFLOW_RGB = 16'hF800
) (
  input  logic           PixelClk,
  input  logic           nRST,
  input  logic [2:0]     mode,
  input  logic [15:0]    solid_rgb,
  output logic           pix_rd,
  input  logic [15:0]    pix_data,
  input  logic           pix_empty,
  output logic           line_fetch,
  output logic [15:0]    fetch_line,
  output logic           frame_start,
  output logic           underflow,
  input  logic           underflow_clr,
  output logic           LCD_DE,
  output logic           LCD_HSYNC,
  output logic           LCD_VSYNC,
  output logic [R_W-1:0] LCD_R,
  output logic [G_W-1:0] LCD_G,
  output logic [B_W-1:0] LCD_B
);
  localparam int          H_TOTAL = H_PULSE + H_BP + H_ACTIVE + H_FP;
  localparam int          V_TOTAL = V_PULSE + V_BP + V_ACTIVE + V_FP;
  localparam logic [15:0] H_P     = 16'(H_PULSE);
  localparam logic [15:0] H_S     = 16'(H_PULSE + H_BP);
  localparam logic [15:0] H_E     = 16'(H_PULSE + H_BP + H_ACTIVE);
  localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_P     = 16'(V_PULSE);
  localparam logic [15:0] V_S     = 16'(V_PULSE + V_BP);
  localparam logic [15:0] V_E     = 16'(V_PULSE + V_BP + V_ACTIVE);
  localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);
  localparam logic [15:0] V_T     = 16'(V_TOTAL);
  if (H_TOTAL >= 65536 || V_TOTAL >= 65536) begin : g_size_chk
    $error("lcd_timing_engine: H_TOTAL and V_TOTAL must be below 65536");
  end
  logic [15:0] h, v, x, y, v2, solid_q, solid_cur, pat_rgb, rgb_q;
  logic [2:0]  mode_q, mode_cur;
  logic        fs0, act0, hs0, vs0, strm, uf_ev;
  logic        de1, hs1, vs1, fs1, rd1, uf1;
  always_comb begin
    fs0       = h == '0 && v == '0;
    act0      = h >= H_S && h < H_E && v >= V_S && v < V_E;
    hs0       = h < H_P;
    vs0       = v < V_P;
    x         = h - H_S;
    y         = v - V_S;
    // the frame-start cycle already uses the freshly sampled mode and colour
    mode_cur  = fs0 ? mode : mode_q;
    solid_cur = fs0 ? solid_rgb : solid_q;
    strm      = act0 && mode_cur == M_STREAM;
    pix_rd    = strm && !pix_empty;
    uf_ev     = strm && pix_empty;
    // line two ahead of the current one: registering at the last h of this
    // line makes line_fetch appear exactly at h=0 of the following line
    v2        = v + 16'd2 >= V_T ? v + 16'd2 - V_T : v + 16'd2;
  end
  always_ff @(posedge PixelClk or negedge nRST)
    if (!nRST) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= h == H_LAST ? '0 : h + 16'd1;
      if (h == H_LAST) v <= v == V_LAST ? '0 : v + 16'd1;
    end
  lcd_pattern_gen #(.H_ACTIVE(H_ACTIVE), .CHECK_LOG2(CHECK_LOG2)) u_pat (
    .PixelClk  (PixelClk),
    .nRST      (nRST),
    .active    (act0),
    .x         (x),
    .y         (y),
    .mode      (mode_cur),
    .solid_rgb (solid_cur),
    .rgb       (pat_rgb)
  );
  always_ff @(posedge PixelClk or negedge nRST)
    if (!nRST) begin
      mode_q      <= '0;
      solid_q     <= '0;
      de1         <= 1'b0;
      hs1         <= 1'b0;
      vs1         <= 1'b0;
      fs1         <= 1'b0;
      rd1         <= 1'b0;
      uf1         <= 1'b0;
      LCD_DE      <= 1'b0;
      LCD_HSYNC   <= ~HS_POL;
      LCD_VSYNC   <= ~VS_POL;
      rgb_q       <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      line_fetch  <= 1'b0;
      fetch_line  <= '0;
    end else begin
      mode_q      <= mode_cur;
      solid_q     <= solid_cur;
      de1         <= act0;
      hs1         <= hs0;
      vs1         <= vs0;
      fs1         <= fs0;
      rd1         <= pix_rd;
      uf1         <= uf_ev;
      LCD_DE      <= de1;
      LCD_HSYNC   <= hs1 ? HS_POL : ~HS_POL;
      LCD_VSYNC   <= vs1 ? VS_POL : ~VS_POL;
      rgb_q       <= rd1 ? pix_data : uf1 ? UNDERFLOW_RGB : pat_rgb;
      frame_start <= fs1;
      underflow   <= uf_ev | (underflow & ~underflow_clr);
      line_fetch  <= h == H_LAST && v2 >= V_S && v2 < V_E;
      fetch_line  <= v2 - V_S;
    end
  assign {LCD_R, LCD_G, LCD_B} = rgb_q;
endmodule
